// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode decoder: strips E0/F0 prefixes, flags typematic repeats and
// queues decoded key events in a small FIFO for a ready/valid consumer.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_repeat,
  output logic [7:0] press_cnt,
  output logic [3:0] err_cnt,
  output logic       overflow,
  input  logic       ov_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  tmo_reg, tmo_next;
  logic           ev_push, ev_ext_next, ev_brk_next;
  logic           held_vld_reg, held_ext_reg;
  logic [7:0]     held_code_reg;
  logic           held_match, is_rep;
  logic [7:0]     press_cnt_reg;
  logic [3:0]     err_cnt_reg;
  logic           overflow_reg;
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    cnt_reg;
  logic           full, pop, push_ok, drop;
  logic [10:0]    mem [FIFO_DEPTH];
  logic [10:0]    head;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  always_comb begin
    state_next  = state_reg;
    tmo_next    = tmo_reg;
    ev_push     = 1'b0;
    ev_ext_next = 1'b0;
    ev_brk_next = 1'b0;
    if (rx_err) begin
      state_next = IDLE;
      tmo_next   = '0;
    end else if (rx_valid) begin
      tmo_next = '0;
      case (state_reg)
        IDLE: begin
          if (rx_data == 8'hE0)      state_next = EXT;
          else if (rx_data == 8'hF0) state_next = BRK;
          else if (!is_ignored(rx_data)) ev_push = 1'b1;
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_next = EXTBRK;
          end else if (rx_data != 8'hE0) begin
            ev_push     = 1'b1;
            ev_ext_next = 1'b1;
            state_next  = IDLE;
          end
        end
        BRK: begin
          ev_push     = 1'b1;
          ev_brk_next = 1'b1;
          state_next  = IDLE;
        end
        default: begin
          ev_push     = 1'b1;
          ev_ext_next = 1'b1;
          ev_brk_next = 1'b1;
          state_next  = IDLE;
        end
      endcase
    end else if (state_reg != IDLE) begin
      // An abandoned prefix must not glue itself onto a much later byte.
      if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
        state_next = IDLE;
        tmo_next   = '0;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end
  end

  assign held_match = held_vld_reg && (held_code_reg == rx_data) && (held_ext_reg == ev_ext_next);
  assign is_rep     = ev_push && !ev_brk_next && held_match;

  assign full    = (cnt_reg == (AW+1)'(FIFO_DEPTH));
  assign pop     = ev_valid && ev_ready;
  assign push_ok = ev_push && (!full || pop);
  assign drop    = ev_push && full && !pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      tmo_reg       <= '0;
      held_vld_reg  <= 1'b0;
      held_ext_reg  <= 1'b0;
      held_code_reg <= '0;
      press_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      overflow_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      if (rx_err && (err_cnt_reg != 4'hF)) err_cnt_reg <= err_cnt_reg + 4'd1;
      // Held-key tracking and press counting ignore whether the FIFO had room.
      if (ev_push && !ev_brk_next && !is_rep) begin
        held_vld_reg  <= 1'b1;
        held_ext_reg  <= ev_ext_next;
        held_code_reg <= rx_data;
        press_cnt_reg <= press_cnt_reg + 8'd1;
      end else if (ev_push && ev_brk_next && held_match) begin
        held_vld_reg <= 1'b0;
      end
      if (drop)        overflow_reg <= 1'b1;
      else if (ov_clr) overflow_reg <= 1'b0;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
        2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {is_rep, ev_brk_next, ev_ext_next, rx_data};
  end

  assign head      = mem[rd_ptr_reg];
  assign ev_valid  = (cnt_reg != '0);
  assign ev_code   = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext    = ev_valid & head[8];
  assign ev_break  = ev_valid & head[9];
  assign ev_repeat = ev_valid & head[10];
  assign press_cnt = press_cnt_reg;
  assign err_cnt   = err_cnt_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed vector table, hand-built corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0, rx_err = 1'b0, ev_ready = 1'b0, ov_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_valid, ev_ext, ev_break, ev_repeat, overflow;
  logic [7:0] ev_code, press_cnt;
  logic [3:0] err_cnt;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_repeat(ev_repeat), .press_cnt(press_cnt), .err_cnt(err_cnt),
    .overflow(overflow), .ov_clr(ov_clr)
  );

  typedef struct { logic [7:0] code; bit ext; bit brk; bit rep; } ev_t;

  // Reference model: pending-prefix flags, quiet-cycle counter, event queue.
  ev_t        m_q[$];
  bit         m_e0, m_f0, m_held_vld, m_held_ext, m_ov;
  logic [7:0] m_held_code;
  int         m_quiet, m_press, m_err;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_e0 = 0; m_f0 = 0; m_held_vld = 0; m_held_ext = 0; m_held_code = 0;
    m_ov = 0; m_quiet = 0; m_press = 0; m_err = 0;
  endtask

  task automatic model_event(input logic [7:0] code, input bit ext, input bit brk,
                             input bit popped, input bit clr);
    ev_t e;
    bit same;
    same = m_held_vld && (m_held_code == code) && (m_held_ext == ext);
    e.code = code; e.ext = ext; e.brk = brk; e.rep = !brk && same;
    if (!brk && !same) begin
      m_held_vld = 1; m_held_code = code; m_held_ext = ext;
      m_press = (m_press + 1) % 256;
    end else if (brk && same) begin
      m_held_vld = 0;
    end
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ov = 1;
  endtask

  task automatic model_update(input bit rst, input bit v, input logic [7:0] d,
                              input bit e, input bit rdy, input bit clr);
    bit popped, ignorable, dropped_before;
    if (rst) begin
      model_reset();
      return;
    end
    popped = (m_q.size() > 0) && rdy;
    if (popped) void'(m_q.pop_front());
    dropped_before = m_ov;
    m_ov = 0;
    ignorable = (d == 8'h00) || (d == 8'hAA) || (d == 8'hEE) ||
                (d == 8'hFA) || (d == 8'hFE) || (d == 8'hFF);
    if (e) begin
      m_e0 = 0; m_f0 = 0; m_quiet = 0;
      if (m_err < 15) m_err++;
    end else if (v) begin
      m_quiet = 0;
      if (m_f0) begin
        model_event(d, m_e0, 1, popped, clr);
        m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
        if (d == 8'hF0) m_f0 = 1;
        else if (d != 8'hE0) begin
          model_event(d, 1, 0, popped, clr);
          m_e0 = 0;
        end
      end else if (d == 8'hE0) m_e0 = 1;
      else if (d == 8'hF0) m_f0 = 1;
      else if (!ignorable) model_event(d, 0, 0, popped, clr);
    end else if (m_e0 || m_f0) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_e0 = 0; m_f0 = 0; m_quiet = 0;
      end
    end
    // m_ov now holds "dropped this cycle"; a new drop outranks ov_clr.
    m_ov = m_ov ? 1'b1 : (clr ? 1'b0 : dropped_before);
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] d,
                      input bit e, input bit rdy, input bit clr);
    @(negedge clk);
    resetn = !rst; rx_valid = v; rx_data = d; rx_err = e; ev_ready = rdy; ov_clr = clr;
    @(posedge clk);
    model_update(rst, v, d, e, rdy, clr);
    #1;
    chk("m_valid", ev_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("m_code", ev_code, m_q[0].code);
      chk("m_ext", ev_ext, m_q[0].ext);
      chk("m_brk", ev_break, m_q[0].brk);
      chk("m_rep", ev_repeat, m_q[0].rep);
    end else begin
      chk("m_idle_outs", {ev_code, ev_ext, ev_break, ev_repeat}, 0);
    end
    chk("m_press", press_cnt, m_press);
    chk("m_err", err_cnt, m_err);
    chk("m_ov", overflow, m_ov);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0, rdy, 0);
  endtask

  typedef struct {
    bit rst; bit v; logic [7:0] d; bit e; bit rdy; bit clr;
    bit x_vld; logic [7:0] x_code; bit x_ext; bit x_brk; bit x_rep; int x_press;
  } vec_t;

  vec_t tbl[24];

  initial begin
    model_reset();
    //         rst v  d      e rdy clr  vld code  ext brk rep press
    tbl[0]  = '{1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 8'h1C, 0, 1, 0,   1, 8'h1C, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 8'hF0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 8'h1C, 0, 1, 0,   1, 8'h1C, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[5]  = '{1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 8'h75, 0, 1, 0,   1, 8'h75, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 8'h75, 0, 1, 0,   1, 8'h75, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 8'hF0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 8'h75, 0, 1, 0,   1, 8'h75, 1, 1, 0, 1};
    tbl[13] = '{0, 1, 8'hAA, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 8'hFA, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[16] = '{1, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 8'h74, 0, 1, 0,   1, 8'h74, 0, 0, 0, 1};
    tbl[18] = '{0, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1};
    tbl[19] = '{0, 1, 8'h1C, 0, 0, 0,   1, 8'h1C, 0, 0, 0, 2};
    tbl[20] = '{0, 0, 8'h00, 0, 0, 0,   1, 8'h1C, 0, 0, 0, 2};
    tbl[21] = '{0, 1, 8'h75, 0, 0, 0,   1, 8'h1C, 0, 0, 0, 3};
    tbl[22] = '{0, 0, 8'h00, 0, 1, 0,   1, 8'h75, 0, 0, 0, 3};
    tbl[23] = '{0, 0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 3};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rdy, tbl[i].clr);
      chk("t_valid", ev_valid, tbl[i].x_vld);
      chk("t_code", ev_code, tbl[i].x_code);
      chk("t_ext", ev_ext, tbl[i].x_ext);
      chk("t_brk", ev_break, tbl[i].x_brk);
      chk("t_rep", ev_repeat, tbl[i].x_rep);
      chk("t_press", press_cnt, tbl[i].x_press);
      $display("vec %0d: in d=%h v=%0d -> valid=%0d code=%h ext=%0d brk=%0d rep=%0d press=%0d",
               i, tbl[i].d, tbl[i].v, ev_valid, ev_code, ev_ext, ev_break, ev_repeat, press_cnt);
    end

    // FIFO overflow: one more make than fits, order kept, sticky flag, clear.
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 1, 8'h11 + 8'(i), 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_press", press_cnt, DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_order", ev_code, 8'h11 + 8'(i));
      step(0, 0, 8'h00, 0, 1, 0);
    end
    chk("ovf_drained", ev_valid, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h21 + 8'(i), 0, 0, 0);
    step(0, 1, 8'h25, 0, 1, 0);
    chk("full_pop_push_nodrop", overflow, 0);
    step(0, 1, 8'h26, 0, 0, 1);
    chk("ovf_set_beats_clr", overflow, 1);
    $display("overflow sequence: ov=%0d press=%0d", overflow, press_cnt);

    // Prefix timeout exactly at the limit, and one cycle short of it.
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hE0, 0, 0, 0);
    idle(TMO, 0);
    step(0, 1, 8'h1C, 0, 0, 0);
    chk("tmo_code", ev_code, 8'h1C);
    chk("tmo_ext", ev_ext, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 1, 8'hE0, 0, 0, 0);
    idle(TMO - 1, 0);
    step(0, 1, 8'h75, 0, 0, 0);
    chk("tmo_short_ext", ev_ext, 1);
    step(0, 0, 8'h00, 0, 1, 0);
    $display("timeout sequence: done");

    // rx_err aborts a prefix, and beats a simultaneous rx_valid.
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hF0, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h1C, 0, 0, 0);
    chk("err_make_brk", ev_break, 0);
    chk("err_cnt1", err_cnt, 1);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 1, 8'h33, 1, 0, 0);
    chk("err_drop_byte", ev_valid, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0, 0);
    chk("err_sat", err_cnt, 15);
    $display("error sequence: err_cnt=%0d", err_cnt);

    // Randomized traffic against the reference model.
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h1C;
        3: b = 8'h75;
        4: b = 8'h74;
        5: b = 8'hAA;
        6: b = 8'hFA;
        7: b = 8'hE0;
        8: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, b,
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 5,
           $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) idle($urandom_range(1, TMO + 2), 0);
    end
    $display("random phase: press=%0d err=%0d", press_cnt, err_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles allowed between prefix byte and its following byte.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse: receiver accepted a frame.
REQ-006 SHALL have port rx_data  input  8  scancode byte; qualified by rx_valid.
REQ-007 SHALL have port rx_err  input  1  one-cycle pulse: receiver rejected a frame (start, stop or parity error).
REQ-008 SHALL have port ev_valid  output  1  event FIFO non-empty.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-010 SHALL have port ev_code  output  8  head event scancode.
REQ-011 SHALL have port ev_ext  output  1  head event carried an E0 prefix.
REQ-012 SHALL have port ev_break  output  1  head event is a release (F0 prefix).
REQ-013 SHALL have port ev_repeat  output  1  head event is a typematic repeat of the held key.
REQ-014 SHALL have port press_cnt  output  8  count of non-repeat make events, wraps.
REQ-015 SHALL have port err_cnt  output  4  count of rx_err pulses, saturating.
REQ-016 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-017 SHALL have port ov_clr  input  1  clears overflow.

Function
REQ-018 SHALL run decoder FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen).
REQ-019 In IDLE, on byte: E0->EXT; F0->BRK; 00/AA/EE/FA/FE/FF discarded, no event, stay IDLE; other->make event {ext=0,break=0}, stay IDLE.
REQ-020 In EXT, on byte: F0->EXTBRK; E0 stays EXT; other->make event {ext=1,break=0}, ->IDLE.
REQ-021 In BRK, on byte: break event {ext=0,break=1}, ->IDLE. In EXTBRK, on byte: break event {ext=1,break=1}, ->IDLE.
REQ-022 SHALL push the event into the FIFO on the clk edge at which rx_valid is sampled high, so ev_valid rises one cycle after that rx_valid when the FIFO was empty.
REQ-023 SHALL keep held-key register {held_vld,held_ext,held_code}; on a make event that equals held_code/held_ext with held_vld=1, ev_repeat=1; otherwise, ev_repeat=0 and the register loads the make event.
REQ-024 SHALL clear held_vld on a break event matching held_code/held_ext; a non-matching break leaves the register unchanged.
REQ-025 SHALL increment press_cnt by 1 on each pushed or dropped make event with ev_repeat=0; 255 wraps to 0.
REQ-026 SHALL, in any non-IDLE state, count cycles without rx_valid; when the count reaches TIMEOUT_CYC, SHALL return to IDLE with no event. The count resets on every state entry.
REQ-027 SHALL, on rx_err, return to IDLE with no event and increment err_cnt saturating at 15; rx_err SHALL take priority if asserted together with rx_valid, and that byte SHALL be discarded.
REQ-028 SHALL pop the FIFO head when ev_valid and ev_ready are both high; ev_* outputs SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-029 If the FIFO is full and no pop occurs that cycle, a new event SHALL be dropped and overflow set. A simultaneous pop and push when full SHALL succeed, with no drop.
REQ-030 SHALL let a set of overflow win over ov_clr in the same cycle.
REQ-031 SHALL keep dropped events updating the held-key register and press_cnt exactly as pushed events do.

Reset
REQ-032 With resetn=0 at a clk edge, SHALL clear the FSM to IDLE, empty the FIFO (ev_valid=0) and clear held_vld, timeout count, press_cnt=0, err_cnt=0 and overflow=0; ev_code/ev_ext/ev_break/ev_repeat SHALL read 0.
REQ-033 Reset mid-sequence, for example after E0, SHALL discard the partial prefix; the next byte SHALL decode from IDLE.

Verification
REQ-034 Bytes 1C, F0,1C with ev_ready=1 -> events {1C,ext0,brk0,rep0}, {1C,ext0,brk1,rep0}; press_cnt=1.
REQ-035 Bytes E0,75, E0,75, E0,F0,75 -> {75,ext1,brk0,rep0}, {75,ext1,brk0,rep1}, {75,ext1,brk1}; press_cnt=1.
REQ-036 ev_ready=0 with FIFO_DEPTH+1 distinct make bytes -> FIFO_DEPTH events retained in order, last dropped, overflow=1; ov_clr -> overflow=0.
REQ-037 E0, then idle for TIMEOUT_CYC cycles, then 1C -> single event {1C,ext0,brk0}; F0 followed by rx_err, then 1C -> make event, err_cnt=1.
REQ-038 Sixteen rx_err pulses -> err_cnt=15; bytes AA, FA in IDLE -> no event; resetn=0 after E0, then 74 -> {74,ext0,brk0}.
